// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback scheduler and mux
package wb_pkg;
    localparam int RD_W = 3;
    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM, SRC_LINK} wb_src_t;
    typedef enum logic {MS_IDLE, MS_WAIT} mem_state_t;
    localparam logic [2:0] VSEL_ALU  = 3'b001;
    localparam logic [2:0] VSEL_MEM  = 3'b010;
    localparam logic [2:0] VSEL_LINK = 3'b100;
    typedef struct packed {
        logic          valid;
        wb_src_t       src;
        logic [RD_W-1:0] rd;
    } slot_t;
    function automatic logic [2:0] vsel_of(wb_src_t s);
        return s == SRC_ALU ? VSEL_ALU : s == SRC_MEM ? VSEL_MEM : s == SRC_LINK ? VSEL_LINK : 3'b000;
    endfunction
endpackage

// File: rtl/wb_sched_if.sv
// wb_sched_if: decode, memory-handshake and writeback signals of the scheduler
interface wb_sched_if #(parameter int NREG = 8, parameter int AW = 3, parameter int PCW = 16);
    import wb_pkg::*;
    logic            id_valid;
    wb_src_t         id_src;
    logic [AW-1:0]   id_rd;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            flush;
    logic            mem_ack;
    logic            id_ready;
    logic            mem_req;
    logic            mdata_le;
    logic [2:0]      vsel;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [NREG-1:0] pending;
    logic [PCW-1:0]  stall_cnt;
    modport master (
        output id_valid, id_src, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, flush, mem_ack,
        input  id_ready, mem_req, mdata_le, vsel, rf_we, rf_waddr, pending, stall_cnt
    );
    modport slave (
        input  id_valid, id_src, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, flush, mem_ack,
        output id_ready, mem_req, mdata_le, vsel, rf_we, rf_waddr, pending, stall_cnt
    );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: in-flight destination map and RAW hazard detect over EX/MEM/WB
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  slot_t           ex,
    input  slot_t           mem,
    input  slot_t           wb,
    input  logic            id_valid,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [NREG-1:0] pending,
    output logic            hazard
);
    function automatic logic [NREG-1:0] dest_of(slot_t s);
        return (s.valid && s.src != SRC_NONE) ? NREG'(1) << s.rd[AW-1:0] : '0;
    endfunction

    // WB is included so a consumer waits until its producer has fully committed
    always_comb begin
        pending = dest_of(ex) | dest_of(mem) | dest_of(wb);
        hazard  = id_valid && ((use_rs1 && pending[rs1]) || (use_rs2 && pending[rs2]));
    end
endmodule

// File: rtl/wb_sched.sv
// wb_sched: tracks issued instructions through EX/MEM/WB and drives writeback control
module wb_sched
    import wb_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int PCW  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_sched_if.slave  bus
);
    slot_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    mem_state_t     state_q, state_d;
    logic [PCW-1:0] stall_q, stall_d;
    logic           mem_block, adv, hazard, issue, load_enter;

    wb_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .ex(ex_q), .mem(mem_q), .wb(wb_q),
        .id_valid(bus.id_valid), .use_rs1(bus.id_use_rs1), .use_rs2(bus.id_use_rs2),
        .rs1(bus.id_rs1), .rs2(bus.id_rs2),
        .pending(bus.pending), .hazard(hazard)
    );

    assign mem_block    = mem_q.valid && mem_q.src == SRC_MEM && !bus.mem_ack;
    assign adv          = !mem_block;
    assign bus.id_ready = adv && !hazard && !bus.flush;
    assign issue        = bus.id_valid && bus.id_ready;
    assign load_enter   = adv && ex_q.valid && ex_q.src == SRC_MEM;
    assign bus.mem_req  = state_q == MS_WAIT;
    assign bus.mdata_le = bus.mem_req && bus.mem_ack;
    assign bus.rf_we    = wb_q.valid && wb_q.src != SRC_NONE;
    assign bus.rf_waddr = wb_q.rd[AW-1:0];
    assign bus.vsel     = bus.rf_we ? vsel_of(wb_q.src) : 3'b000;
    assign bus.stall_cnt = stall_q;

    // Pipeline slot advance; a memory stall freezes EX/MEM and retires WB as a bubble
    always_comb begin
        ex_d    = !adv ? ex_q : issue ? slot_t'{1'b1, bus.id_src, RD_W'(bus.id_rd)} : '0;
        mem_d   = adv ? ex_q : mem_q;
        wb_d    = adv ? mem_q : '0;
        stall_d = (bus.id_valid && !bus.id_ready && !bus.flush && stall_q != '1) ? stall_q + PCW'(1) : stall_q;
    end

    // Memory request FSM; a load arriving as the previous one is acked re-arms WAIT
    always_comb begin
        state_d = state_q;
        if (load_enter)
            state_d = MS_WAIT;
        else if (state_q == MS_WAIT && bus.mem_ack)
            state_d = MS_IDLE;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= MS_IDLE;
            stall_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: randomized and directed scoreboard bench for wb_sched
module tb_wb_sched;
    import wb_pkg::*;

    typedef struct {int rd; int src; int stg;} ent_t;
    typedef struct {int rd; int vsel;} wr_t;

    logic clk = 0;
    logic rst_n = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_stall = 0;
    ent_t fl_q[$];
    wr_t  exp_q[$];

    wb_sched_if bus ();
    wb_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, int src, int rd, int rs1, int rs2, bit u1, bit u2, bit fl, bit ack);
        bus.id_valid = v; bus.id_src = wb_src_t'(2'(src)); bus.id_rd = 3'(rd);
        bus.id_rs1 = 3'(rs1); bus.id_rs2 = 3'(rs2); bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
        bus.flush = fl; bus.mem_ack = ack;
    endtask

    // One clock of stimulus: model predicts every output, then advances its instruction list
    task automatic cyc(bit v, int src, int rd, int rs1, int rs2, bit u1, bit u2, bit fl, bit ack);
        bit mreq = 0, haz = 0, we = 0, blk, rdy;
        int vs = 0;
        int pend = 0;
        @(negedge clk);
        drive(v, src, rd, rs1, rs2, u1, u2, fl, ack);
        #1;
        foreach (fl_q[i]) begin
            pend |= 1 << fl_q[i].rd;
            if (fl_q[i].stg == 1 && fl_q[i].src == 2) mreq = 1;
            if (fl_q[i].stg == 2) begin we = 1; vs = 1 << (fl_q[i].src - 1); end
            if ((u1 && fl_q[i].rd == rs1) || (u2 && fl_q[i].rd == rs2)) haz = 1;
        end
        blk = mreq && !ack;
        rdy = !blk && !(v && haz) && !fl;
        chk("id_ready", 32'(bus.id_ready), int'(rdy));
        chk("mem_req", 32'(bus.mem_req), int'(mreq));
        chk("mdata_le", 32'(bus.mdata_le), int'(mreq && ack));
        chk("pending", 32'(bus.pending), pend);
        chk("stall_cnt", 32'(bus.stall_cnt), exp_stall);
        chk("rf_we", 32'(bus.rf_we), int'(we));
        chk("vsel_idle", 32'(bus.vsel), we ? vs : 0);
        if (v && !rdy && !fl && exp_stall != 65535) exp_stall++;
        if (blk) begin
            for (int i = fl_q.size() - 1; i >= 0; i--) if (fl_q[i].stg == 2) fl_q.delete(i);
        end else begin
            foreach (fl_q[i]) fl_q[i].stg++;
            for (int i = fl_q.size() - 1; i >= 0; i--) if (fl_q[i].stg > 2) fl_q.delete(i);
        end
        if (v && rdy && src != 0) begin
            fl_q.push_back('{rd, src, 0});
            exp_q.push_back('{rd, 1 << (src - 1)});
        end
    endtask

    task automatic idle(int n, bit ack);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, ack);
    endtask

    // Asynchronous reset mid-cycle; every output must clear before the next edge
    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 0;
        #1;
        chk("rst_vsel", 32'(bus.vsel), 0);
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        chk("rst_id_ready", 32'(bus.id_ready), 1);
        chk("rst_mdata_le", 32'(bus.mdata_le), 0);
        fl_q.delete();
        exp_q.delete();
        exp_stall = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Write monitor: every register-file write must match the oldest expected one
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_write: got rd=%0d vsel=%b expected no write", bus.rf_waddr, bus.vsel);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_waddr", 32'(bus.rf_waddr), e.rd);
                    chk("vsel", 32'(bus.vsel), e.vsel);
                end
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        // ALU write to r2
        cyc(1, 1, 2, 0, 0, 0, 0, 0, 0);
        idle(5, 0);
        // Load r3 with ack two cycles late, younger ALU r4 behind it, r5 stalled
        cyc(1, 2, 3, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 1);
        idle(5, 0);
        // RAW on r1: three stall cycles
        do_reset();
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 4, 1, 0, 1, 0, 0, 0);
        idle(1, 0);
        chk("stall_cnt_raw", 32'(bus.stall_cnt), 3);
        idle(4, 0);
        // LINK r7, then a flushed issue
        cyc(1, 3, 7, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 0, 0, 1, 0);
        idle(5, 0);
        // Zero-wait load
        cyc(1, 2, 6, 0, 0, 0, 0, 0, 1);
        idle(5, 1);
        // Reset while a load waits in MEM
        cyc(1, 2, 5, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        do_reset();
        idle(5, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4);
        idle(10, 1);
        // Saturate the stall counter against a load that never returns
        cyc(1, 2, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65541; i++) cyc(1, 1, 2, 5, 0, 1, 0, 0, 0);
        chk("stall_cnt_sat", 32'(bus.stall_cnt), 16'hFFFF);
        idle(10, 1);
        chk("writes_left", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
